// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    SKIP
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int   RW_BIT   = 0;

  function automatic int ptr_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer, FILTER_LEN-sample glitch filter and edge pulses for one
// oversampled I2C line. Edge pulses coincide with the cycle level_o changes.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        rise_q  <= sync_q[1];
        fall_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register file to the bus and to fabric logic;
// oversamples SCL/SDA in the clk domain and never stretches the clock.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         NUM_REGS   = 8,
  parameter int         FILTER_LEN = 3,
  localparam int        PW         = ptr_width(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  input  logic                  usr_wr_en,
  input  logic [PW-1:0]         usr_wr_addr,
  input  logic [7:0]            usr_wr_data,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic                  wr_stb,
  output logic [PW-1:0]         wr_idx,
  output logic                  busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk    (clk),
    .rst_n  (rst),
    .line_i (scl_i),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk    (clk),
    .rst_n  (rst),
    .line_i (sda_i),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_state_e    state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [PW-1:0] ptr_q;
  logic          rw_q;
  logic          sda_oe_q;
  logic          busy_q;
  logic          wr_stb_q;
  logic [PW-1:0] wr_idx_q;
  logic [7:0]    regs_q [NUM_REGS];

  logic          start_det, stop_det, bit_last, i2c_we;
  logic [7:0]    shift_d;
  logic [PW-1:0] ptr_inc;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign bit_last  = (bit_cnt_q == 3'd7);
  assign shift_d   = {shift_q[6:0], sda_lvl};
  // NUM_REGS is a power of two, so the natural PW-bit wrap is the modulo.
  assign ptr_inc   = ptr_q + PW'(1);
  assign i2c_we    = (state_q == WDATA) && scl_rise && bit_last && !start_det && !stop_det;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b1;
      end else if (stop_det) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ADDR, PTR, WDATA: begin
            if (scl_fall) sda_oe_q <= 1'b0;
            if (scl_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_last) begin
                case (state_q)
                  ADDR: begin
                    if (shift_d[7:1] == DEV_ADDR) begin
                      rw_q    <= shift_d[RW_BIT];
                      state_q <= ADDR_ACK;
                    end else begin
                      state_q <= SKIP;
                    end
                  end
                  PTR: begin
                    ptr_q   <= shift_d[PW-1:0];
                    state_q <= PTR_ACK;
                  end
                  default: begin
                    wr_stb_q <= 1'b1;
                    wr_idx_q <= ptr_q;
                    ptr_q    <= ptr_inc;
                    state_q  <= WDATA_ACK;
                  end
                endcase
              end
            end
          end
          // Entered on the last bit's rise: the next fall starts the ACK slot,
          // the following rise is the initiator sampling it.
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) sda_oe_q <= ~I2C_ACK;
            if (scl_rise) begin
              bit_cnt_q <= '0;
              if (state_q == ADDR_ACK && rw_q) begin
                shift_q <= regs_q[ptr_q];
                state_q <= RDATA;
              end else if (state_q == ADDR_ACK) begin
                state_q <= PTR;
              end else begin
                state_q <= WDATA;
              end
            end
          end
          RDATA: begin
            if (scl_fall) begin
              sda_oe_q <= ~shift_q[7];
              shift_q  <= {shift_q[6:0], 1'b0};
            end
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_last) state_q <= RACK;
            end
          end
          RACK: begin
            if (scl_fall) sda_oe_q <= 1'b0;
            if (scl_rise) begin
              ptr_q     <= ptr_inc;
              bit_cnt_q <= '0;
              if (sda_lvl == I2C_ACK) begin
                shift_q <= regs_q[ptr_inc];
                state_q <= RDATA;
              end else begin
                state_q <= SKIP;
              end
            end
          end
          SKIP:    sda_oe_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // NOTE: the register file is reset explicitly because firmware and fabric
  // consumers rely on all-zero contents after reset; it cannot map to RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (usr_wr_en) regs_q[usr_wr_addr] <= usr_wr_data;
      if (i2c_we)    regs_q[ptr_q]       <= shift_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[8*g +: 8] = regs_q[g];
  end

  assign sda_oe = sda_oe_q;
  assign wr_stb = wr_stb_q;
  assign wr_idx = wr_idx_q;
  assign busy   = busy_q;

endmodule
